pio_edge_poller: RTL and testbench



---
 rtl/pio_edge_poller.sv | 150 +++++++++++++++
 tb/tb_pio_edge_poller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pio_edge_poller.sv
// Avalon-MM master that polls an edge-capture PIO slave on a fixed schedule.
// When the edge-capture register is non-zero it clears it, snapshots the live
// input data and presents one event on a valid/ready stream.
module pio_edge_poller #(
  parameter int WIDTH        = 10,
  parameter int POLL_DIV     = 1000,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_data,
  output logic             busy
);

  localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(POLL_DIV - 1);
  localparam logic [LW-1:0] LAT_MAX   = LW'(READ_LATENCY - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_EDGE,
    WAIT_E,
    CLR,
    RD_DATA,
    WAIT_D,
    EMIT
  } state_t;

  state_t           state, state_next;
  logic [TW-1:0]    timer, timer_next;
  logic [LW-1:0]    lat_cnt, lat_next;
  logic [WIDTH-1:0] edge_reg, edge_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [WIDTH-1:0] rd_low;

  // Only the low WIDTH bits of the slave read data carry PIO bits.
  logic unused_readdata;
  assign unused_readdata = &{1'b0, avm_readdata};
  assign rd_low = avm_readdata[WIDTH-1:0];

  // Next-state logic: poll timer, read-latency wait, edge/data capture.
  always_comb begin
    state_next = state;
    timer_next = timer;
    lat_next   = lat_cnt;
    edge_next  = edge_reg;
    data_next  = data_reg;
    case (state)
      IDLE: begin
        if (enable) begin
          if (timer == '0) state_next = RD_EDGE;
          else             timer_next = timer - 1'b1;
        end else begin
          timer_next = TIMER_MAX;
        end
      end
      RD_EDGE: begin
        state_next = WAIT_E;
        lat_next   = LAT_MAX;
      end
      WAIT_E: begin
        if (lat_cnt == '0) begin
          edge_next = rd_low;
          if (rd_low == '0) begin
            state_next = IDLE;
            timer_next = TIMER_MAX;
          end else begin
            state_next = CLR;
          end
        end else begin
          lat_next = lat_cnt - 1'b1;
        end
      end
      CLR: begin
        state_next = RD_DATA;
      end
      RD_DATA: begin
        state_next = WAIT_D;
        lat_next   = LAT_MAX;
      end
      WAIT_D: begin
        if (lat_cnt == '0) begin
          data_next  = rd_low;
          state_next = EMIT;
        end else begin
          lat_next = lat_cnt - 1'b1;
        end
      end
      EMIT: begin
        if (evt_ready) begin
          state_next = IDLE;
          timer_next = TIMER_MAX;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = TIMER_MAX;
      end
    endcase
  end

  // State registers plus outputs registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= TIMER_MAX;
      lat_cnt        <= '0;
      edge_reg       <= '0;
      data_reg       <= '0;
      avm_address    <= ADDR_DATA;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 32'h0;
      evt_valid      <= 1'b0;
      evt_edges      <= '0;
      evt_data       <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      lat_cnt        <= lat_next;
      edge_reg       <= edge_next;
      data_reg       <= data_next;
      avm_chipselect <= (state_next == RD_EDGE) || (state_next == CLR) ||
                        (state_next == RD_DATA);
      avm_address    <= ((state_next == RD_EDGE) || (state_next == CLR)) ?
                        ADDR_EDGE : ADDR_DATA;
      avm_write_n    <= (state_next != CLR);
      avm_writedata  <= (state_next == CLR) ? 32'hFFFF_FFFF : 32'h0;
      evt_valid      <= (state_next == EMIT);
      evt_edges      <= (state_next == EMIT) ? edge_next : '0;
      evt_data       <= (state_next == EMIT) ? data_next : '0;
      busy           <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_pio_edge_poller.sv
// Directed bench for pio_edge_poller with a registered edge-capture PIO slave model.
module tb_pio_edge_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [9:0]  evt_edges;
  logic [9:0]  evt_data;
  logic        busy;

  logic [9:0]  in_port;
  logic [9:0]  in_prev;
  logic [9:0]  slave_edge;
  logic        model_clr;
  logic        hi_override;

  int checks = 0;
  int errors = 0;

  pio_edge_poller #(.WIDTH(10), .POLL_DIV(4), .READ_LATENCY(1)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .avm_address(avm_address),
    .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n),
    .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_edges(evt_edges),
    .evt_data(evt_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // PIO slave: rising-edge capture, clear on write to address 3, one-cycle registered reads.
  always @(posedge clk) begin
    in_prev <= in_port;
    if (model_clr)
      slave_edge <= '0;
    else if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
      slave_edge <= in_port & ~in_prev;
    else
      slave_edge <= slave_edge | (in_port & ~in_prev);
    if (avm_chipselect && avm_write_n)
      avm_readdata <= (avm_address == 2'd3) ?
                      ({22'h0, slave_edge} | (hi_override ? 32'hFFFF_FC00 : 32'h0)) :
                      {22'h0, in_port};
    else
      avm_readdata <= 32'h0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset DUT and slave model; on return we are at cycle 0 with reset released.
  task automatic applyStimulus(input logic en);
    reset       = 1'b1;
    model_clr   = 1'b1;
    in_port     = '0;
    evt_ready   = 1'b1;
    enable      = en;
    hi_override = 1'b0;
    step();
    step();
    model_clr = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; evt_ready = 1'b0; in_port = '0;
    model_clr = 1'b1; hi_override = 1'b0;

    // Reset state
    applyStimulus(1'b1);
    checkOutput("rst_cs", avm_chipselect, 1'b0);
    checkOutput("rst_write_n", avm_write_n, 1'b1);
    checkOutput("rst_addr", avm_address, 2'd0);
    checkOutput("rst_wdata", avm_writedata, 32'h0);
    checkOutput("rst_valid", evt_valid, 1'b0);
    checkOutput("rst_edges", evt_edges, 10'h0);
    checkOutput("rst_data", evt_data, 10'h0);
    checkOutput("rst_busy", busy, 1'b0);

    // Test 1: no edges, polls at 4, 10, 16
    for (int c = 1; c <= 17; c++) begin
      step();
      checkOutput("t1_write_n", avm_write_n, 1'b1);
      checkOutput("t1_valid", evt_valid, 1'b0);
      checkOutput("t1_cs", avm_chipselect, (c == 4 || c == 10 || c == 16));
      if (c == 4) checkOutput("t1_addr", avm_address, 2'd3);
    end

    // Test 2: single edge on bit 2
    applyStimulus(1'b1);
    for (int c = 1; c <= 12; c++) begin
      step();
      checkOutput("t2_cs", avm_chipselect, (c == 4 || c == 6 || c == 7));
      checkOutput("t2_write_n", avm_write_n, (c != 6));
      checkOutput("t2_valid", evt_valid, (c == 9));
      if (c == 4) checkOutput("t2_rd_edge_addr", avm_address, 2'd3);
      if (c == 6) begin
        checkOutput("t2_clr_addr", avm_address, 2'd3);
        checkOutput("t2_clr_wdata", avm_writedata, 32'hFFFF_FFFF);
      end
      if (c == 7) checkOutput("t2_rd_data_addr", avm_address, 2'd0);
      if (c == 9) begin
        checkOutput("t2_edges", evt_edges, 10'h004);
        checkOutput("t2_data", evt_data, 10'h004);
        checkOutput("t2_busy_emit", busy, 1'b1);
      end
      if (c == 10) checkOutput("t2_busy_idle", busy, 1'b0);
      if (c == 12) checkOutput("t2_slave_cleared", slave_edge, 10'h000);
      if (c == 1) in_port = 10'h004;
    end

    // Test 3: backpressure with a new edge during the stall
    applyStimulus(1'b1);
    evt_ready = 1'b0;
    for (int c = 1; c <= 38; c++) begin
      step();
      checkOutput("t3_cs", avm_chipselect, (c == 4 || c == 6 || c == 7 ||
                                           c == 33 || c == 35 || c == 36));
      checkOutput("t3_valid", evt_valid, ((c >= 9 && c <= 28) || c == 38));
      if (c >= 9 && c <= 28) begin
        checkOutput("t3_hold_edges", evt_edges, 10'h201);
        checkOutput("t3_hold_data", evt_data, 10'h201);
      end
      if (c == 38) begin
        checkOutput("t3_next_edges", evt_edges, 10'h020);
        checkOutput("t3_next_data", evt_data, 10'h221);
      end
      if (c == 1) in_port = 10'h201;
      if (c == 12) in_port = 10'h221;
      if (c == 28) evt_ready = 1'b1;
    end

    // Test 4: enable low, re-enabled, then dropped during CLR
    applyStimulus(1'b1);
    for (int c = 1; c <= 40; c++) begin
      step();
      checkOutput("t4_cs", avm_chipselect, (c == 24 || c == 26 || c == 27));
      checkOutput("t4_valid", evt_valid, (c == 29));
      if (c == 26) checkOutput("t4_clr_write_n", avm_write_n, 1'b0);
      if (c == 29) begin
        checkOutput("t4_edges", evt_edges, 10'h001);
        checkOutput("t4_data", evt_data, 10'h001);
      end
      if (c == 30) checkOutput("t4_busy_idle", busy, 1'b0);
      if (c == 2) enable = 1'b0;
      if (c == 20) begin
        enable  = 1'b1;
        in_port = 10'h001;
      end
      if (c == 26) enable = 1'b0;
    end

    // Test 5: reset taken at the edge that would enter CLR
    applyStimulus(1'b1);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) in_port = 10'h008;
    end
    checkOutput("t5_wait_e_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    checkOutput("t5_rst_cs", avm_chipselect, 1'b0);
    checkOutput("t5_rst_write_n", avm_write_n, 1'b1);
    checkOutput("t5_rst_valid", evt_valid, 1'b0);
    checkOutput("t5_rst_busy", busy, 1'b0);
    checkOutput("t5_slave_pending", slave_edge, 10'h008);
    reset = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      checkOutput("t5_cs", avm_chipselect, (c == 4 || c == 6 || c == 7));
      checkOutput("t5_valid", evt_valid, (c == 9));
      if (c == 9) begin
        checkOutput("t5_edges", evt_edges, 10'h008);
        checkOutput("t5_data", evt_data, 10'h008);
      end
    end

    // Test 6: only upper read bits set, treated as no edges
    applyStimulus(1'b1);
    hi_override = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      step();
      checkOutput("t6_write_n", avm_write_n, 1'b1);
      checkOutput("t6_valid", evt_valid, 1'b0);
      checkOutput("t6_cs", avm_chipselect, (c == 4 || c == 10 || c == 16));
      if (c == 5) checkOutput("t6_busy_wait", busy, 1'b1);
      if (c == 6) checkOutput("t6_busy_idle", busy, 1'b0);
    end
    hi_override = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
